// File: rtl/alu_issue_pkg.sv
// Shared ALU request types and codes for the issue stage and the ALU.
// Used by alu_issue (optional perf counters: ALU_ISSUE_PERF_EN).
package alu_issue_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SHL = 3'b001;
  localparam logic [2:0] ALU_LTS = 3'b010;
  localparam logic [2:0] ALU_LTU = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SHR = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  funct;
    logic        sw;
    logic [4:0]  rd;
    logic        illegal;
  } alu_req_t;

  localparam int REQ_W = $bits(alu_req_t);

endpackage

// File: rtl/alu_issue_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with registered in_ready.
// Main slot drives the outputs; skid slot absorbs one beat of backpressure.
module skid_buf #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         r_main_v;
  logic [W-1:0] r_main_d;
  logic         r_skid_v;
  logic [W-1:0] r_skid_d;
  logic         r_rdy;

  logic w_acc;
  logic w_load;

  assign w_acc  = in_valid & r_rdy;
  assign w_load = ~r_main_v | out_ready;

  // r_rdy low implies skid full, so an accept never collides with a skid move
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_main_v <= 1'b0;
      r_main_d <= '0;
      r_skid_v <= 1'b0;
      r_skid_d <= '0;
      r_rdy    <= 1'b1;
    end else if (w_load) begin
      r_main_v <= r_skid_v | w_acc;
      if (r_skid_v)
        r_main_d <= r_skid_d;
      else if (w_acc)
        r_main_d <= in_data;
      r_skid_v <= 1'b0;
      r_rdy    <= 1'b1;
    end else if (w_acc) begin
      r_skid_v <= 1'b1;
      r_skid_d <= in_data;
      r_rdy    <= 1'b0;
    end
  end

  assign in_ready  = r_rdy;
  assign out_valid = r_main_v;
  assign out_data  = r_main_d;

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes OP/OP-IMM/LUI/AUIPC into ALU requests.
// Define ALU_ISSUE_PERF_EN to add perf_issued/perf_stall counters.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      funct,
  output logic            sw,
  output logic [4:0]      rd,
  output logic            illegal
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]     perf_issued,
  output logic [31:0]     perf_stall
`endif
);

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_u;
  logic        w_is_op;
  logic        w_is_opimm;
  logic        w_is_lui;
  logic        w_is_auipc;
  logic        w_op_bad;
  logic        w_imm_bad;
  alu_req_t    w_req;
  alu_req_t    w_out;

  assign w_opc   = in_inst[6:0];
  assign w_f3    = in_inst[14:12];
  assign w_f7    = in_inst[31:25];
  assign w_imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign w_imm_u = {in_inst[31:12], 12'b0};

  assign w_is_op    = (w_opc == OPC_OP);
  assign w_is_opimm = (w_opc == OPC_OPIMM);
  assign w_is_lui   = (w_opc == OPC_LUI);
  assign w_is_auipc = (w_opc == OPC_AUIPC);

  assign w_op_bad =
    (w_f7 != 7'b0000000 && w_f7 != 7'b0100000) ||
    (w_f7 == 7'b0100000 &&
     w_f3 != ALU_ADD && w_f3 != ALU_SHR);

  // Shift-immediates reuse funct7 as an encoding field
  assign w_imm_bad =
    (w_f3 == ALU_SHL && w_f7 != 7'b0000000) ||
    (w_f3 == ALU_SHR &&
     w_f7 != 7'b0000000 && w_f7 != 7'b0100000);

  always_comb begin
    w_req       = '0;
    w_req.rd    = in_inst[11:7];
    w_req.funct = ALU_ADD;
    unique case (1'b1)
      w_is_op: begin
        w_req.a       = in_rs1;
        w_req.b       = in_rs2;
        w_req.funct   = w_f3;
        w_req.sw      = in_inst[30];
        w_req.illegal = w_op_bad;
      end
      w_is_opimm: begin
        w_req.a       = in_rs1;
        w_req.b       = w_imm_i;
        w_req.funct   = w_f3;
        w_req.sw      = (w_f3 == ALU_SHR) & in_inst[30];
        w_req.illegal = w_imm_bad;
      end
      w_is_lui: begin
        w_req.b = w_imm_u;
      end
      w_is_auipc: begin
        w_req.a = in_pc;
        w_req.b = w_imm_u;
      end
      default: begin
        w_req.illegal = 1'b1;
      end
    endcase
    // Illegal entries still flow so writeback can raise the trap
    if (w_req.illegal) begin
      w_req.a     = '0;
      w_req.b     = '0;
      w_req.funct = ALU_ADD;
      w_req.sw    = 1'b0;
      w_req.rd    = '0;
    end
  end

  skid_buf #(
    .W(REQ_W)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out)
  );

  assign alu_a   = w_out.a;
  assign alu_b   = w_out.b;
  assign funct   = w_out.funct;
  assign sw      = w_out.sw;
  assign rd      = w_out.rd;
  assign illegal = w_out.illegal;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_perf_issued <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (out_valid & out_ready)
        r_perf_issued <= r_perf_issued + 32'd1;
      if (out_valid & ~out_ready)
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_issued = r_perf_issued;
  assign perf_stall  = r_perf_stall;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: expected requests queued on accept,
// compared in order as the ALU side consumes them.
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  funct;
  logic        sw;
  logic [4:0]  rd;
  logic        illegal;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_stall;
`endif

  int checks = 0;
  int errors = 0;
  alu_req_t sb[$];
  logic rand_on = 1'b0;

  alu_issue dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .funct     (funct),
    .sw        (sw),
    .rd        (rd),
    .illegal   (illegal)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic alu_req_t model(
    input logic [31:0] inst,
    input logic [31:0] pc,
    input logic [31:0] rs1,
    input logic [31:0] rs2
  );
    alu_req_t   r;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ok;
    f3 = inst[14:12];
    f7 = inst[31:25];
    r = '0;
    r.rd = inst[11:7];
    ok = 1'b1;
    if (inst[6:0] == 7'h33) begin
      ok = (f7 == 7'h00) ||
           (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      r.a = rs1;
      r.b = rs2;
      r.funct = f3;
      r.sw = inst[30];
    end else if (inst[6:0] == 7'h13) begin
      if (f3 == 3'd1)
        ok = (f7 == 7'h00);
      else if (f3 == 3'd5)
        ok = (f7 == 7'h00) || (f7 == 7'h20);
      r.a = rs1;
      r.b = 32'($signed(inst[31:20]));
      r.funct = f3;
      r.sw = (f3 == 3'd5) ? inst[30] : 1'b0;
    end else if (inst[6:0] == 7'h37) begin
      r.b = inst & 32'hFFFF_F000;
    end else if (inst[6:0] == 7'h17) begin
      r.a = pc;
      r.b = inst & 32'hFFFF_F000;
    end else begin
      ok = 1'b0;
    end
    if (!ok) begin
      r = '0;
      r.illegal = 1'b1;
    end
    return r;
  endfunction

  always @(negedge clock) begin
    alu_req_t got;
    alu_req_t exp;
    if (!reset && out_valid && out_ready) begin
      got = '{alu_a, alu_b, funct, sw, rd, illegal};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_spurious got=%h required=none", got);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL sb_req got a=%h b=%h f=%0d sw=%b rd=%0d ill=%b required a=%h b=%h f=%0d sw=%b rd=%0d ill=%b",
            got.a, got.b, got.funct, got.sw, got.rd, got.illegal,
            exp.a, exp.b, exp.funct, exp.sw, exp.rd, exp.illegal);
        end
      end
    end
  end

  // Leaves in_valid high; caller lowers it when the burst ends
  task automatic push_in(
    input logic [31:0] inst,
    input logic [31:0] pc,
    input logic [31:0] rs1,
    input logic [31:0] rs2
  );
    int n;
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    in_rs1   = rs1;
    in_rs2   = rs2;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout got in_ready=0 required=1");
    end else begin
      sb.push_back(model(inst, pc, rs1, rs2));
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain;
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_left got=%0d required=0", sb.size());
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_valid got=%b required=0", out_valid);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    in_valid = 1'b0;
    in_inst = '0;
    in_pc = '0;
    in_rs1 = '0;
    in_rs2 = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs got v=%b r=%b required v=0 r=1",
        out_valid, in_ready);
    end
    checks++;
    if ({alu_a, alu_b, funct, sw, rd, illegal} !== 74'd0) begin
      errors++;
      $display("FAIL reset_data got a=%h b=%h required 0", alu_a, alu_b);
    end
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_add;
    out_ready = 1'b1;
    push_in(32'h002081B3, 32'h0, 32'd5, 32'd7);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || alu_a !== 32'd5 || alu_b !== 32'd7 ||
        funct !== 3'b000 || sw !== 1'b0 || rd !== 5'd3) begin
      errors++;
      $display("FAIL add_latency got v=%b a=%h b=%h rd=%0d required v=1 a=5 b=7 rd=3",
        out_valid, alu_a, alu_b, rd);
    end
    drain();
  endtask

  task automatic test_imm;
    out_ready = 1'b1;
    push_in(32'h40335293, 32'h0, 32'h8000_0000, 32'h0);
    checks++;
    if (alu_b !== 32'h0000_0403 || funct !== 3'b101 || sw !== 1'b1 ||
        rd !== 5'd5) begin
      errors++;
      $display("FAIL srai got b=%h f=%0d sw=%b rd=%0d required b=403 f=5 sw=1 rd=5",
        alu_b, funct, sw, rd);
    end
    push_in(32'h40000093, 32'h0, 32'h0, 32'h0);
    checks++;
    if (alu_b !== 32'h0000_0400 || funct !== 3'b000 || sw !== 1'b0) begin
      errors++;
      $display("FAIL addi got b=%h f=%0d sw=%b required b=400 f=0 sw=0",
        alu_b, funct, sw);
    end
    push_in(32'hFFF00113, 32'h0, 32'd9, 32'h0);
    drain();
  endtask

  task automatic test_upper;
    out_ready = 1'b1;
    push_in(32'h123450B7, 32'h4, 32'hDEAD_BEEF, 32'h0);
    checks++;
    if (alu_a !== 32'h0 || alu_b !== 32'h1234_5000 || rd !== 5'd1) begin
      errors++;
      $display("FAIL lui got a=%h b=%h required a=0 b=12345000", alu_a, alu_b);
    end
    push_in(32'h00001117, 32'h8000_0000, 32'h0, 32'h0);
    checks++;
    if (alu_a !== 32'h8000_0000 || alu_b !== 32'h0000_1000 ||
        funct !== 3'b000) begin
      errors++;
      $display("FAIL auipc got a=%h b=%h f=%0d required a=80000000 b=1000 f=0",
        alu_a, alu_b, funct);
    end
    drain();
  endtask

  task automatic test_illegal;
    out_ready = 1'b1;
    push_in(32'h0000000B, 32'h0, 32'd1, 32'd2);
    checks++;
    if (out_valid !== 1'b1 || illegal !== 1'b1 || rd !== 5'd0 ||
        alu_a !== 32'h0) begin
      errors++;
      $display("FAIL ill_opc got v=%b ill=%b rd=%0d required v=1 ill=1 rd=0",
        out_valid, illegal, rd);
    end
    push_in(32'h4020E1B3, 32'h0, 32'd1, 32'd2);
    checks++;
    if (illegal !== 1'b1 || funct !== 3'b000) begin
      errors++;
      $display("FAIL ill_f7 got ill=%b f=%0d required ill=1 f=0",
        illegal, funct);
    end
    push_in(32'h40009093, 32'h0, 32'd1, 32'd2);
    push_in(32'h402081B3, 32'h0, 32'd9, 32'd4);
    drain();
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    push_in(32'h002081B3, 32'h0, 32'd11, 32'd1);
    push_in(32'h402081B3, 32'h0, 32'd22, 32'd2);
    in_inst = 32'h0020C1B3;
    in_rs1 = 32'd33;
    in_rs2 = 32'd3;
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          alu_a !== 32'd11) begin
        errors++;
        $display("FAIL bp_hold got r=%b v=%b a=%0d required r=0 v=1 a=11",
          in_ready, out_valid, alu_a);
      end
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    push_in(32'h0020C1B3, 32'h0, 32'd33, 32'd3);
    drain();
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_in(32'h002081B3 | (32'(i) << 7), 32'h0, 32'(i), 32'(i * 3));
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready idx=%0d got=%b required=1", i, in_ready);
      end
    end
    drain();
  endtask

  task automatic test_random;
    logic [6:0] opcs [5];
    opcs[0] = 7'h33;
    opcs[1] = 7'h13;
    opcs[2] = 7'h37;
    opcs[3] = 7'h17;
    opcs[4] = 7'h5B;
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [31:0] inst;
          inst = $urandom;
          if ($urandom_range(0, 1) == 0)
            inst[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
          inst[6:0] = opcs[$urandom_range(0, 4)];
          push_in(inst, $urandom, $urandom, $urandom);
        end
        in_valid = 1'b0;
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clock);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    push_in(32'h002081B3, 32'h0, 32'd1, 32'd2);
    push_in(32'h002081B3, 32'h0, 32'd3, 32'd4);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_a !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid got v=%b r=%b a=%h required v=0 r=1 a=0",
        out_valid, in_ready, alu_a);
    end
`ifdef ALU_ISSUE_PERF_EN
    checks++;
    if (perf_issued !== 32'h0 || perf_stall !== 32'h0) begin
      errors++;
      $display("FAIL rst_perf got i=%0d s=%0d required 0 0",
        perf_issued, perf_stall);
    end
`endif
    sb.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_residue got v=%b required=0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_upper();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Issue stage that feeds the execute-unit ALU: the producer end of the ALU's operand/funct/sw interface.
- Accepts a decoded-to-register instruction (inst, pc, rs1/rs2 values) over a valid/ready handshake.
- Classifies OP, OP-IMM, LUI and AUIPC, generates ALU operands plus funct/sw controls, and registers them toward the ALU through a 2-entry skid buffer, giving full throughput with registered in_ready.

Parameters:
XLEN, 32, operand width; only 32 is supported.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  upstream holds a valid instruction
in_ready  out  1  stage can accept; driven from a register
in_inst  in  32  RV32 instruction word
in_pc  in  32  instruction PC
in_rs1  in  32  rs1 register value
in_rs2  in  32  rs2 register value
out_valid  out  1  ALU request valid
out_ready  in  1  ALU/writeback consumes the request
alu_a  out  32  ALU operand A
alu_b  out  32  ALU operand B
funct  out  3  ALU_ADD..ALU_AND code
sw  out  1  subtract / arithmetic-shift select
rd  out  5  destination register
illegal  out  1  opcode/funct7 not in the supported set

Behaviour:
- Reset (async, active-high): out_valid=0, in_ready=1, skid empty. Data outputs are 0.
- Handshake: a transfer occurs when valid&&ready on a cycle edge. Latency is 1 cycle from in-accept to out_valid. out_* stays stable while out_valid&&!out_ready.
- Skid buffer: two slots, main (drives outputs) and skid.
  - in_ready = !skid_full, registered.
  - Accept when main is full and out_ready=0: data goes to skid, and in_ready drops next cycle.
  - When main drains: skid moves to main in the same edge.
  - Simultaneous accept + drain with skid empty: new entry goes to main. Back-to-back throughput is 1/cycle.
- Operand generation:
  - OP (0110011): a=rs1, b=rs2, funct=inst[14:12], sw=inst[30].
  - OP-IMM (0010011): a=rs1, b=sext(inst[31:20]), funct=inst[14:12], sw=inst[30] only when funct==101. For ADDI/SLTI/etc., sw=0 regardless of the immediate bit.
  - LUI: a=0, b={inst[31:12],12'b0}, funct=ALU_ADD, sw=0.
  - AUIPC: a=pc, b={inst[31:12],12'b0}, funct=ALU_ADD, sw=0.
  - rd=inst[11:7] for all of the above.
- illegal=1 when:
  - the opcode is outside the set above, or
  - OP has funct7 ∉ {0000000, 0100000}, or
  - OP with funct7=0100000 and funct3 ∉ {000, 101}, or
  - SLLI/SRLI/SRAI has an invalid inst[31:25].
  - When illegal=1: funct=ALU_ADD, a=b=0, rd=0, and the entry still flows (out_valid=1) so downstream can trap.
- Reset mid-transfer: both slots are discarded immediately. No partial entry survives.

Optional Feature:
- ALU_ISSUE_PERF_EN defined: adds outputs perf_issued[31:0] and perf_stall[31:0].
  - perf_issued increments on each out handshake.
  - perf_stall increments on each cycle with out_valid&&!out_ready.
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent, with no behavioural change.

Decomposition:
- Shared package holds:
  - ALU funct constants (ALU_ADD=000, ALU_SHL=001, ALU_LTS=010, ALU_LTU=011, ALU_XOR=100, ALU_SHR=101, ALU_OR=110, ALU_AND=111), shared with the ALU;
  - opcode constants (OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC);
  - a packed struct alu_req_t {a, b, funct, sw, rd, illegal}.
- One natural sub-module: skid_buf, a generic 2-entry valid/ready buffer parameterised on payload width. The decode logic stays in alu_issue.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, a=5, b=7, funct=000, sw=0, rd=3.
- SRAI x5,x6,3 (0x40335293), rs1=0x80000000 → b=0x00000403, funct=101, sw=1, rd=5. ADDI x1,x0,0x400 (0x40000093) → funct=000, sw=0.
- LUI x1,0x12345 (0x123450B7) → a=0, b=0x12345000. AUIPC with pc=0x80000000 → a=0x80000000, funct=000.
- Backpressure: 3 back-to-back inputs with out_ready=0 → first two accepted, in_ready=0 from cycle 2. Raise out_ready → drains in order, no loss or duplication.
- Illegal: 0x0000000B → out_valid=1, illegal=1, rd=0. OP funct7=0100000 with funct3=110 → illegal=1.
- Assert reset mid-stall with 2 entries held → out_valid=0 and in_ready=1 immediately. PERF counters (if enabled) read 0.
